tone_sequencer: RTL and testbench



---
 rtl/tone_pkg.sv | 21 ++
 rtl/tone_cmd_fifo.sv | 58 +++++
 rtl/tone_sequencer.sv | 174 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared state encoding, default field widths and command record for the tone sequencer.
package tone_pkg;

  localparam int HP_W_DEF  = 20;
  localparam int DUR_W_DEF = 16;
  localparam int VOL_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } seq_state_t;

  typedef struct packed {
    logic [HP_W_DEF-1:0]  hp;
    logic [DUR_W_DEF-1:0] dur;
    logic [VOL_W-1:0]     vol;
  } tone_cmd_t;

endpackage

// File: rtl/tone_cmd_fifo.sv
// Small synchronous FIFO holding queued note commands.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: pushes are ignored when full, pops when empty; flush wins over both.
module tone_cmd_fifo
  import tone_pkg::*;
#(
  parameter type T     = tone_cmd_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued notes as a square-wave duty envelope with a silent gap between notes.
// Latency: IDLE and LOAD take one cycle each; outputs are registered one cycle behind state.
// Backpressure: cmd_ready drops when the FIFO is full or while stop is asserted.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int  TICK_CYCLES = 100000,
  parameter int  GAP_TICKS   = 10,
  parameter int  FIFO_DEPTH  = 4,
  parameter int  HP_W        = HP_W_DEF,
  parameter int  DUR_W       = DUR_W_DEF,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [HP_W-1:0]  cmd_half_period,
  input  logic [DUR_W-1:0] cmd_duration,
  input  logic [VOL_W-1:0] cmd_volume,
  input  logic             stop,
  output logic [VOL_W-1:0] duty_cycle,
  output logic             audio_enable,
  output logic             busy,
  output logic             note_done,
  output logic [CW-1:0]    fifo_count
);

  localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST  = (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;

  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
    logic [VOL_W-1:0] vol;
  } note_t;

  seq_state_t       state;
  seq_state_t       state_nxt;
  note_t            cmd_in;
  note_t            head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] dur_q;
  logic [VOL_W-1:0] vol_q;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] tick_cnt;
  logic [HP_W-1:0]  half_cnt;
  logic             phase;

  logic             tick_end;
  logic             play_last;
  logic             gap_last;
  logic             half_end;
  logic [VOL_W-1:0] duty_d;
  logic             audio_d;
  logic             done_d;
  logic             busy_d;

  assign cmd_in.hp  = cmd_half_period;
  assign cmd_in.dur = cmd_duration;
  assign cmd_in.vol = cmd_volume;

  assign cmd_ready = !fifo_full && !stop;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == LOAD) && !stop;

  tone_cmd_fifo #(
    .T     (note_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .flush     (stop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Tick counter compares against dur-1 so a full-scale duration never wraps it.
  assign tick_end  = (presc == TICK_LAST);
  assign play_last = (state == PLAY) && tick_end && (tick_cnt == dur_q - DUR_W'(1));
  assign gap_last  = (state == GAP) && tick_end && (32'(tick_cnt) == GAP_LAST);
  assign half_end  = (half_cnt == hp_q - HP_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      duty_cycle   <= '0;
      audio_enable <= 1'b0;
      note_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      duty_cycle   <= duty_d;
      audio_enable <= audio_d;
      note_done    <= done_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) state_nxt = LOAD;
        LOAD:    state_nxt = (head.dur == '0) ? IDLE : PLAY;
        PLAY:    if (play_last) state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
        GAP:     if (gap_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    audio_d = (state == PLAY) && (hp_q != '0);
    duty_d  = (audio_d && phase) ? vol_q : '0;
    done_d  = !stop && (play_last || ((state == LOAD) && (head.dur == '0)));
    busy_d  = (state != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q     <= '0;
      dur_q    <= '0;
      vol_q    <= '0;
      presc    <= '0;
      tick_cnt <= '0;
      half_cnt <= '0;
      phase    <= 1'b1;
    end else if (stop || (state == IDLE)) begin
      presc    <= '0;
      tick_cnt <= '0;
      half_cnt <= '0;
      phase    <= 1'b1;
    end else if (state == LOAD) begin
      hp_q     <= head.hp;
      dur_q    <= head.dur;
      vol_q    <= head.vol;
      presc    <= '0;
      tick_cnt <= '0;
      half_cnt <= '0;
      phase    <= 1'b1;
    end else begin
      // PLAY and GAP share the prescaler; the tick counter restarts at each boundary.
      if (tick_end) begin
        presc    <= '0;
        tick_cnt <= (play_last || gap_last) ? '0 : tick_cnt + DUR_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if ((state == PLAY) && (hp_q != '0)) begin
        if (half_end) begin
          half_cnt <= '0;
          phase    <= !phase;
        end else begin
          half_cnt <= half_cnt + HP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: two sequencers (gap of 2 ticks and no gap) checked against hand-derived notes.
module tb_tone_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic        valid_a, valid_b, ready_a, ready_b, stop_a, stop_b;
  logic [19:0] hp_a, hp_b;
  logic [15:0] dur_a, dur_b;
  logic [9:0]  vol_a, vol_b, duty_a, duty_b;
  logic        ae_a, ae_b, busy_a, busy_b, nd_a, nd_b;
  logic [2:0]  cnt_a, cnt_b;

  tone_sequencer #(.TICK_CYCLES(10), .GAP_TICKS(2), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset_a), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_half_period(hp_a), .cmd_duration(dur_a), .cmd_volume(vol_a), .stop(stop_a),
    .duty_cycle(duty_a), .audio_enable(ae_a), .busy(busy_a), .note_done(nd_a),
    .fifo_count(cnt_a)
  );

  tone_sequencer #(.TICK_CYCLES(10), .GAP_TICKS(0), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset_b), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_half_period(hp_b), .cmd_duration(dur_b), .cmd_volume(vol_b), .stop(stop_b),
    .duty_cycle(duty_b), .audio_enable(ae_b), .busy(busy_b), .note_done(nd_b),
    .fifo_count(cnt_b)
  );

  typedef struct {
    int ae_cycles;
    int hp;
    int vol;
    int gap_before;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc[2]     = '{0, 0};
  int   derr[2]    = '{0, 0};
  int   quiet[2]   = '{0, 0};
  int   sil_bad[2] = '{0, 0};
  int   stray[2]   = '{0, 0};
  bit   mon_en[2]  = '{1'b0, 1'b0};

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic expect_note(input int d, input int cyc, input int hp, input int vol, input int gap);
    exp_t e;
    e = '{cyc, hp, vol, gap};
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Per-cycle monitor: accumulates the audible window of the head note and scores it at note_done.
  task automatic mon_step(input int d, input logic ae, input logic [9:0] duty, input logic nd);
    exp_t e;
    bit   have;
    int   want;
    e = '{0, 0, 0, -1};
    if (d == 0) begin
      have = (q_a.size() != 0);
      if (have) e = q_a[0];
    end else begin
      have = (q_b.size() != 0);
      if (have) e = q_b[0];
    end
    if (!mon_en[d]) begin
      acc[d] = 0; derr[d] = 0; quiet[d] = 0;
      if (nd) stray[d]++;
      return;
    end
    if (!ae && duty != 10'd0) sil_bad[d]++;
    if (ae) begin
      if (!have || e.hp == 0) begin
        stray[d]++;
      end else begin
        if (acc[d] == 0 && e.gap_before >= 0)
          check($sformatf("gap_before_note_dut%0d", d), quiet[d], e.gap_before);
        want = ((acc[d] / e.hp) % 2 == 0) ? e.vol : 0;
        if (int'(duty) != want) derr[d]++;
      end
      acc[d]++;
      quiet[d] = 0;
    end else begin
      quiet[d]++;
    end
    if (nd) begin
      if (!have) begin
        stray[d]++;
      end else begin
        check($sformatf("ae_cycles_dut%0d", d), acc[d], e.ae_cycles);
        check($sformatf("duty_pattern_errs_dut%0d", d), derr[d], 0);
        if (d == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
      end
      acc[d] = 0;
      derr[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, ae_a, duty_a, nd_a);
    mon_step(1, ae_b, duty_b, nd_b);
  end

  // Returns at the negedge right after the accepting posedge.
  task automatic push(input int d, input int hp, input int dur, input int vol,
                      output int waited, output int cnt_at_accept);
    int n = 0;
    @(negedge clk);
    if (d == 0) begin
      valid_a = 1'b1; hp_a = 20'(hp); dur_a = 16'(dur); vol_a = 10'(vol);
    end else begin
      valid_b = 1'b1; hp_b = 20'(hp); dur_b = 16'(dur); vol_b = 10'(vol);
    end
    while (!((d == 0) ? ready_a : ready_b) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", (d == 0) ? ready_a : ready_b, 1);
    cnt_at_accept = (d == 0) ? int'(cnt_a) : int'(cnt_b);
    waited = n;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w, c;
    reset_a = 1'b1; reset_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    hp_a = '0; dur_a = '0; vol_a = '0; hp_b = '0; dur_b = '0; vol_b = '0;
    #12;
    check("reset_duty", duty_a, 0);
    check("reset_audio_enable", ae_a, 0);
    check("reset_note_done", nd_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_fifo_count", cnt_a, 0);
    check("reset_cmd_ready", ready_a, 1);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    mon_en[0] = 1'b1; mon_en[1] = 1'b1;

    // Single note: 20 audible cycles, 700x3 / 0x3, then a 20-cycle gap.
    expect_note(0, 20, 3, 700, -1);
    push(0, 3, 2, 700, w, c);
    k = 0;
    while (!nd_a && k < 200) begin @(negedge clk); k++; end
    check("single_done_cycle", k, 22);
    while (busy_a && k < 200) begin @(negedge clk); k++; end
    check("single_idle_cycle", k, 43);

    // Rest note then zero-duration note.
    expect_note(0, 0, 0, 500, -1);
    push(0, 0, 3, 500, w, c);
    k = 0;
    while (!nd_a && k < 200) begin @(negedge clk); k++; end
    check("rest_done_cycle", k, 32);
    while (busy_a && k < 200) begin @(negedge clk); k++; end
    check("rest_idle", busy_a, 0);
    expect_note(0, 0, 5, 900, -1);
    push(0, 5, 0, 900, w, c);
    k = 0;
    while (!nd_a && k < 200) begin @(negedge clk); k++; end
    check("zero_dur_done_cycle", k, 2);
    while (busy_a && k < 200) begin @(negedge clk); k++; end
    check("zero_dur_idle_cycle", k, 3);

    // FIFO full behind a long note.
    expect_note(0, 1000, 3, 100, -1);
    push(0, 3, 100, 100, w, c);
    expect_note(0, 10, 1, 5, -1);    push(0, 1, 1, 5, w, c);
    expect_note(0, 10, 2, 1023, -1); push(0, 2, 1, 1023, w, c);
    expect_note(0, 0, 0, 200, -1);   push(0, 0, 1, 200, w, c);
    expect_note(0, 10, 4, 512, -1);  push(0, 4, 1, 512, w, c);
    check("full_fifo_count", cnt_a, 4);
    check("full_cmd_ready", ready_a, 0);
    expect_note(0, 10, 5, 3, -1);
    push(0, 5, 1, 3, w, c);
    check("full_fifth_waited", (w > 900) ? 1 : 0, 1);
    check("full_fifth_count_at_accept", c, 3);
    k = 0;
    while (busy_a && k < 1000) begin @(negedge clk); k++; end
    check("full_drain_idle", busy_a, 0);

    // Stop during PLAY with two notes queued: no note_done may follow.
    mon_en[0] = 1'b0;
    push(0, 2, 5, 300, w, c);
    push(0, 4, 2, 100, w, c);
    push(0, 1, 1, 50, w, c);
    repeat (8) @(negedge clk);
    check("stop_pre_audio", ae_a, 1);
    check("stop_pre_count", cnt_a, 2);
    stop_a = 1'b1; valid_a = 1'b1; hp_a = 20'd1; dur_a = 16'd1;
    #1;
    check("stop_cmd_ready", ready_a, 0);
    @(negedge clk);
    stop_a = 1'b0; valid_a = 1'b0;
    check("stop_count_next", cnt_a, 0);
    @(negedge clk);
    check("stop_duty", duty_a, 0);
    check("stop_audio_enable", ae_a, 0);
    check("stop_busy", busy_a, 0);
    repeat (100) @(negedge clk);
    check("stop_stays_idle", busy_a, 0);
    mon_en[0] = 1'b1;

    // Asynchronous reset in the middle of PLAY, then a clean note.
    mon_en[0] = 1'b0;
    push(0, 3, 5, 400, w, c);
    push(0, 1, 1, 1, w, c);
    repeat (8) @(negedge clk);
    check("rst_pre_audio", ae_a, 1);
    check("rst_pre_count", cnt_a, 1);
    #2 reset_a = 1'b1;
    #1;
    check("rst_audio_enable", ae_a, 0);
    check("rst_duty", duty_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fifo_count", cnt_a, 0);
    check("rst_note_done", nd_a, 0);
    @(negedge clk);
    reset_a = 1'b0;
    mon_en[0] = 1'b1;
    expect_note(0, 20, 2, 77, -1);
    push(0, 2, 2, 77, w, c);
    k = 0;
    while (!nd_a && k < 200) begin @(negedge clk); k++; end
    check("post_rst_done_cycle", k, 22);

    // Back-to-back notes with no gap: two silent cycles between windows.
    expect_note(1, 10, 2, 600, -1);
    expect_note(1, 10, 2, 250, 2);
    push(1, 2, 1, 600, w, c);
    push(1, 2, 1, 250, w, c);
    k = 2;
    while (!nd_b && k < 200) begin @(negedge clk); k++; end
    check("b2b_first_done_cycle", k, 12);
    @(negedge clk);
    k++;
    while (!nd_b && k < 200) begin @(negedge clk); k++; end
    check("b2b_second_done_cycle", k, 24);

    repeat (30) @(negedge clk);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    check("silent_duty_nonzero_a", sil_bad[0], 0);
    check("silent_duty_nonzero_b", sil_bad[1], 0);
    check("unexpected_output_a", stray[0], 0);
    check("unexpected_output_b", stray[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
